// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the arbiter's request, write-port, scoreboard-mark and
// busy-query signals. The arbiter takes the slave view; producers and
// issue logic take the master view.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              i_req0_valid;
  logic [ADDR_W-1:0] i_req0_addr;
  logic [DATA_W-1:0] i_req0_data;
  logic              o_req0_ready;

  logic              i_req1_valid;
  logic [ADDR_W-1:0] i_req1_addr;
  logic [DATA_W-1:0] i_req1_data;
  logic              o_req1_ready;

  logic              o_we;
  logic [ADDR_W-1:0] o_waddr;
  logic [DATA_W-1:0] o_wdata;

  logic              i_mark_valid;
  logic [ADDR_W-1:0] i_mark_addr;
  logic [ADDR_W-1:0] i_qaddr1;
  logic [ADDR_W-1:0] i_qaddr2;
  logic              o_busy1;
  logic              o_busy2;

  modport slave (
    input  i_req0_valid, i_req0_addr, i_req0_data,
    output o_req0_ready,
    input  i_req1_valid, i_req1_addr, i_req1_data,
    output o_req1_ready,
    output o_we, o_waddr, o_wdata,
    input  i_mark_valid, i_mark_addr, i_qaddr1, i_qaddr2,
    output o_busy1, o_busy2
  );

  modport master (
    output i_req0_valid, i_req0_addr, i_req0_data,
    input  o_req0_ready,
    output i_req1_valid, i_req1_addr, i_req1_data,
    input  o_req1_ready,
    input  o_we, o_waddr, o_wdata,
    output i_mark_valid, i_mark_addr, i_qaddr1, i_qaddr2,
    input  o_busy1, o_busy2
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the pipeline writeback
// (requester 0) and the multi-cycle unit (requester 1). Each requester
// has a one-entry holding register; held writes drain round-robin.
// A pending bit per register tracks outstanding multi-cycle results so
// issue logic can stall on them.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  logic              h0_vld;
  logic [ADDR_W-1:0] h0_addr;
  logic [DATA_W-1:0] h0_data;
  logic              h1_vld;
  logic [ADDR_W-1:0] h1_addr;
  logic [DATA_W-1:0] h1_data;

  // 1 means requester 1 won the most recent two-way conflict
  logic              last_grant;
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;

  logic              both_vld;
  logic              grant0;
  logic              grant1;
  logic              accept0;
  logic              accept1;

  // Round-robin grant from the current holding-register valid bits;
  // nothing is granted while reset is high so no write escapes
  always_comb begin
    both_vld = h0_vld && h1_vld;
    grant0   = 1'b0;
    grant1   = 1'b0;
    if (!reset) begin
      if (both_vld) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = h0_vld;
        grant1 = h1_vld;
      end
    end
  end

  // A draining entry can be refilled on the same edge
  assign bus.o_req0_ready = !h0_vld || grant0;
  assign bus.o_req1_ready = !h1_vld || grant1;
  assign accept0 = bus.i_req0_valid && bus.o_req0_ready;
  assign accept1 = bus.i_req1_valid && bus.o_req1_ready;

  // Write port driven from the granted entry; r0 drains without a write
  always_comb begin
    bus.o_we    = 1'b0;
    bus.o_waddr = '0;
    bus.o_wdata = '0;
    if (grant0) begin
      bus.o_waddr = h0_addr;
      bus.o_wdata = h0_data;
      bus.o_we    = (h0_addr != '0);
    end else if (grant1) begin
      bus.o_waddr = h1_addr;
      bus.o_wdata = h1_data;
      bus.o_we    = (h1_addr != '0);
    end
  end

  // Holding-register valid bits: load on accept, clear when drained
  always_ff @(posedge clk) begin
    if (reset) begin
      h0_vld <= 1'b0;
      h1_vld <= 1'b0;
    end else begin
      if (accept0)     h0_vld <= 1'b1;
      else if (grant0) h0_vld <= 1'b0;
      if (accept1)     h1_vld <= 1'b1;
      else if (grant1) h1_vld <= 1'b0;
    end
  end

  // Holding-register payloads; only meaningful while the valid bit is set
  always_ff @(posedge clk) begin
    if (accept0) begin
      h0_addr <= bus.i_req0_addr;
      h0_data <= bus.i_req0_data;
    end
    if (accept1) begin
      h1_addr <= bus.i_req1_addr;
      h1_data <= bus.i_req1_data;
    end
  end

  // Round-robin pointer moves only when both entries competed
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (both_vld) begin
      last_grant <= grant1;
    end
  end

  // Pending scoreboard: h1 grant clears, a mark sets and wins ties
  always_comb begin
    pending_nxt = pending;
    if (grant1) begin
      pending_nxt[h1_addr] = 1'b0;
    end
    if (bus.i_mark_valid && (bus.i_mark_addr != '0)) begin
      pending_nxt[bus.i_mark_addr] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Pending scoreboard register
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // r0 is never pending, so a query of address 0 reads back 0
  assign bus.o_busy1 = pending[bus.i_qaddr1];
  assign bus.o_busy2 = pending[bus.i_qaddr2];

endmodule
